// File: rtl/i2s_sample_drain.sv
// i2s_sample_drain: drains raw samples from the I2S receiver FIFO (FWFT head),
// sign-extends each one from sample_size, pairs L/R (or duplicates a mono
// sample) and presents the frame on a valid/ready stream.
// Optional build macro: I2S_DRAIN_DECIM2_EN enables a 2:1 averaging decimator.
//
// Stream handshake: m_data is held stable while m_valid is high; a beat
// transfers on a rising clk edge where m_valid && m_ready, after which
// m_valid drops in the following cycle. m_valid never depends on m_ready.
//
// dbg_state exposes the FSM encoding: 0 WAIT_L, 1 GAP_L, 2 WAIT_R, 3 SEND.
module i2s_sample_drain #(
  parameter int DW = 32,
  parameter int LW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stereo,
  input  logic [4:0]      sample_size,
  input  logic [LW-1:0]   fifo_level,
  input  logic [DW-1:0]   fifo_rdata,
  output logic            fifo_rd,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [2*DW-1:0] m_data,
  output logic [15:0]     frame_cnt,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    WAIT_L = 2'd0,
    GAP_L  = 2'd1,
    WAIT_R = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            rd_q;
  logic [DW-1:0]   l_q;
  logic [2*DW-1:0] m_data_q;
  logic [15:0]     frame_cnt_q;

  logic [DW-1:0]   head_ext;
  logic            frame_done;
  logic            emit;
  logic            handshake;
  logic [DW-1:0]   frame_l;
  logic [DW-1:0]   frame_r;
  logic [DW-1:0]   out_l;
  logic [DW-1:0]   out_r;

  // Sign-extend a right-justified sample of n bits; n == 0 keeps the full word.
  function automatic logic [DW-1:0] sext(input logic [DW-1:0] w, input logic [4:0] n);
    logic [DW-1:0] hi;
    hi = {DW{1'b1}} << n;
    if (n == 5'd0) begin
      return w;
    end
    return w[n - 5'd1] ? (w | hi) : (w & ~hi);
  endfunction

  assign head_ext  = sext(fifo_rdata, sample_size);
  assign handshake = m_valid && m_ready;

  // A frame is complete on the R pop, or on the L pop when running mono.
  assign frame_done = fifo_rd && ((state_q == WAIT_R) || ((state_q == WAIT_L) && !stereo));
  assign frame_l    = (state_q == WAIT_L) ? head_ext : l_q;
  assign frame_r    = head_ext;

`ifdef I2S_DRAIN_DECIM2_EN
  logic            phase_q;
  logic [DW-1:0]   acc_l_q;
  logic [DW-1:0]   acc_r_q;
  logic [DW:0]     sum_l;
  logic [DW:0]     sum_r;

  // Average of the stored frame and the current one, floor rounding.
  always_comb begin
    sum_l = {acc_l_q[DW-1], acc_l_q} + {frame_l[DW-1], frame_l};
    sum_r = {acc_r_q[DW-1], acc_r_q} + {frame_r[DW-1], frame_r};
    out_l = sum_l[DW:1];
    out_r = sum_r[DW:1];
    emit  = frame_done && phase_q;
  end

  // Decimator phase: first frame of a pair is parked, second one emits.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase_q <= 1'b0;
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else if (frame_done) begin
      phase_q <= ~phase_q;
      if (!phase_q) begin
        acc_l_q <= frame_l;
        acc_r_q <= frame_r;
      end
    end
  end
`else
  // Every assembled frame is sent unmodified.
  always_comb begin
    out_l = frame_l;
    out_r = frame_r;
    emit  = frame_done;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_L;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; en low always returns to WAIT_L.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = WAIT_L;
    end else begin
      case (state_q)
        WAIT_L: begin
          if (fifo_rd) begin
            if (stereo)    state_d = GAP_L;
            else if (emit) state_d = SEND;
            else           state_d = WAIT_L;
          end
        end
        GAP_L:  state_d = WAIT_R;
        WAIT_R: begin
          if (fifo_rd) state_d = emit ? SEND : WAIT_L;
        end
        SEND: begin
          if (handshake) state_d = WAIT_L;
        end
        default: state_d = WAIT_L;
      endcase
    end
  end

  // FSM outputs; rd_q keeps pops at least one cycle apart so the level can settle.
  always_comb begin
    fifo_rd   = !rst && en && !rd_q && (fifo_level != '0) &&
                ((state_q == WAIT_L) || (state_q == WAIT_R));
    m_valid   = (state_q == SEND);
    m_data    = m_data_q;
    frame_cnt = frame_cnt_q;
    dbg_state = state_q;
  end

  // Datapath: left capture, output frame, pop history and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= 1'b0;
      l_q         <= '0;
      m_data_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      rd_q <= fifo_rd;
      if (fifo_rd && (state_q == WAIT_L)) begin
        l_q <= head_ext;
      end
      if (emit) begin
        m_data_q <= {out_r, out_l};
      end
      if (handshake) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_drain.sv
// Testbench for i2s_sample_drain: a queue-backed FIFO model feeds the DUT,
// a negedge monitor collects accepted frames and protocol observations, and
// each scenario task compares them against frames computed from the sample
// rules with plain integer arithmetic.
module tb_i2s_sample_drain;

  localparam int DW = 32;
  localparam int LW = 5;
`ifdef I2S_DRAIN_DECIM2_EN
  localparam int DECIM_F = 2;
`else
  localparam int DECIM_F = 1;
`endif

  logic            clk;
  logic            rst;
  logic            en;
  logic            stereo;
  logic [4:0]      sample_size;
  logic [LW-1:0]   fifo_level;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_rd;
  logic            m_valid;
  logic            m_ready;
  logic [2*DW-1:0] m_data;
  logic [15:0]     frame_cnt;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  i2s_sample_drain #(.DW(DW), .LW(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .stereo      (stereo),
    .sample_size (sample_size),
    .fifo_level  (fifo_level),
    .fifo_rdata  (fifo_rdata),
    .fifo_rd     (fifo_rd),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .frame_cnt   (frame_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- FIFO model ----------------
  logic [DW-1:0]   fq[$];
  logic            gate = 1'b0;

  task automatic refresh_fifo();
    fifo_rdata = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
    if (gate || fq.size() == 0) fifo_level = '0;
    else if (fq.size() > 31)    fifo_level = 5'd31;
    else                        fifo_level = 5'(fq.size());
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    refresh_fifo();
  endtask

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      #1;
      if (fq.size() > 0) void'(fq.pop_front());
      refresh_fifo();
    end
  end

  // ---------------- Monitor ----------------
  logic [2*DW-1:0] got_q[$];
  logic [2*DW-1:0] exp_q[$];
  int cyc, rd_cnt, consec_err, empty_rd_err, send_rd_err, hold_err;
  int last_rd_cyc, valid_rise_cyc;
  logic prev_rd, prev_valid, prev_ready, prev_en;
  logic [2*DW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_en = 1'b0;
      prev_data = '0;
    end else begin
      cyc++;
      if (fifo_rd === 1'b1) begin
        rd_cnt++;
        if (prev_rd) consec_err++;
        if (fifo_level == '0) empty_rd_err++;
        if (m_valid === 1'b1) send_rd_err++;
        last_rd_cyc = cyc;
      end
      if (m_valid === 1'b1 && !prev_valid) valid_rise_cyc = cyc;
      if (prev_valid && !prev_ready && prev_en && (m_valid !== 1'b1 || m_data !== prev_data))
        hold_err++;
      if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
      prev_rd    = (fifo_rd === 1'b1);
      prev_valid = (m_valid === 1'b1);
      prev_ready = m_ready;
      prev_en    = en;
      prev_data  = m_data;
    end
  end

  // ---------------- Reference model ----------------
  function automatic logic [DW-1:0] model_sext(input logic [DW-1:0] w, input int n);
    longint v;
    if (n == 0) return w;
    v = longint'(w) % (longint'(1) << n);
    if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = (longint'($signed(a)) + longint'($signed(b))) >>> 1;
    return s[DW-1:0];
  endfunction

  task automatic model_frames(input logic [DW-1:0] words[$], input bit st, input int n);
    logic [2*DW-1:0] fr[$];
    logic [DW-1:0] l, r;
    int i = 0;
    while (i < words.size()) begin
      if (st) begin
        if (i + 1 >= words.size()) break;
        l = model_sext(words[i], n);
        r = model_sext(words[i+1], n);
        i += 2;
      end else begin
        l = model_sext(words[i], n);
        r = l;
        i += 1;
      end
      fr.push_back({r, l});
    end
    if (DECIM_F == 2) begin
      for (int j = 0; j + 1 < fr.size(); j += 2)
        exp_q.push_back({model_avg(fr[j][2*DW-1:DW], fr[j+1][2*DW-1:DW]),
                         model_avg(fr[j][DW-1:0],    fr[j+1][DW-1:0])});
    end else begin
      foreach (fr[k]) exp_q.push_back(fr[k]);
    end
  endtask

  // ---------------- Driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; gate = 1'b0; m_ready = 1'b0;
    fq.delete();
    refresh_fifo();
    tick();
    tick();
    got_q.delete(); exp_q.delete();
    cyc = 0; rd_cnt = 0; consec_err = 0; empty_rd_err = 0; send_rd_err = 0;
    hold_err = 0; last_rd_cyc = -1; valid_rise_cyc = -1;
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input bit rand_ready, output bit to);
    for (int i = 0; i < budget && got_q.size() < n; i++) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    to = (got_q.size() < n);
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; stereo = 1'b1; sample_size = 5'd0; m_ready = 1'b1;
    fq.delete();
    push_word(32'h1234_5678);
    tick();
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd got %b want 0", fifo_rd); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    checks++; if (fq.size() != 1) begin errors++; $display("FAIL reset_no_pop fifo words %0d want 1", fq.size()); end
  endtask

`ifndef I2S_DRAIN_DECIM2_EN
  task automatic test_stereo18();
    bit to;
    do_reset();
    stereo = 1'b1; sample_size = 5'd18; m_ready = 1'b1;
    push_word(32'h0003FFFF);
    push_word(32'h00020000);
    en = 1'b1;
    wait_frames(1, 50, 1'b0, to);
    repeat (5) tick();
    checks++; if (to) begin errors++; $display("FAIL stereo18_timeout got %0d frames want 1", got_q.size()); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL stereo18_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== 64'hFFFE0000_FFFFFFFF) begin
        errors++; $display("FAIL stereo18_data got %h want fffe0000ffffffff", got_q[0]);
      end
    end
    checks++; if (rd_cnt != 2) begin errors++; $display("FAIL stereo18_pops got %0d want 2", rd_cnt); end
    checks++; if (valid_rise_cyc != last_rd_cyc + 1) begin
      errors++; $display("FAIL stereo18_latency valid at %0d want %0d", valid_rise_cyc, last_rd_cyc + 1); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL stereo18_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_mono16();
    bit to;
    do_reset();
    stereo = 1'b0; sample_size = 5'd16; m_ready = 1'b1;
    push_word(32'h00007FFF);
    push_word(32'h00008000);
    exp_q.push_back(64'h00007FFF_00007FFF);
    exp_q.push_back(64'hFFFF8000_FFFF8000);
    en = 1'b1;
    wait_frames(2, 50, 1'b0, to);
    repeat (3) tick();
    checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL mono16_count got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mono16_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL mono16_frame_cnt got %0d want 2", frame_cnt); end
    checks++; if (consec_err != 0) begin errors++; $display("FAIL mono16_consec_rd got %0d want 0", consec_err); end
  endtask
`else
  task automatic test_decim8();
    bit to;
    do_reset();
    stereo = 1'b1; sample_size = 5'd8; m_ready = 1'b1;
    push_word(32'h02); push_word(32'h05); push_word(32'h03); push_word(32'hFF);
    en = 1'b1;
    wait_frames(1, 60, 1'b0, to);
    repeat (5) tick();
    checks++; if (to || got_q.size() != 1) begin errors++; $display("FAIL decim8_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== 64'h00000002_00000002) begin errors++; $display("FAIL decim8_data got %h want 0000000200000002", got_q[0]); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL decim8_frame_cnt got %0d want 1", frame_cnt); end
  endtask
`endif

  task automatic test_backpressure();
    logic [DW-1:0] words[$];
    bit to;
    int n;
    do_reset();
    stereo = 1'b1; n = $urandom_range(0, 31); sample_size = 5'(n); m_ready = 1'b0;
    for (int i = 0; i < 6 * DECIM_F; i++) begin
      words.push_back($urandom());
      push_word(words[i]);
    end
    model_frames(words, 1'b1, n);
    en = 1'b1;
    repeat (10 + 4 * DECIM_F) tick();
    checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold got %0d want 0", hold_err); end
    checks++; if (send_rd_err != 0) begin errors++; $display("FAIL bp_rd_in_send got %0d want 0", send_rd_err); end
    checks++; if (rd_cnt != 2 * DECIM_F) begin errors++; $display("FAIL bp_stalled_pops got %0d want %0d", rd_cnt, 2 * DECIM_F); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", m_valid); end
    m_ready = 1'b1;
    wait_frames(3, 80, 1'b0, to);
    repeat (3) tick();
    checks++; if (to || got_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bp_frame_cnt got %0d want 3", frame_cnt); end
  endtask

  task automatic test_gap();
    logic [DW-1:0] words[$];
    bit to;
    int n, cnt;
    bit st;
    do_reset();
    st = 1'($urandom_range(0, 1)); n = $urandom_range(0, 31);
    stereo = st; sample_size = 5'(n); m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      words.push_back($urandom());
      push_word(words[i]);
    end
    model_frames(words, st, n);
    en = 1'b1;
    for (int i = 0; i < 300 && fq.size() != 0; i++) begin
      gate = 1'($urandom_range(0, 1));
      refresh_fifo();
      tick();
    end
    gate = 1'b0;
    refresh_fifo();
    cnt = exp_q.size();
    wait_frames(cnt, 40, 1'b0, to);
    repeat (3) tick();
    checks++; if (consec_err != 0) begin errors++; $display("FAIL gap_consec_rd got %0d want 0", consec_err); end
    checks++; if (empty_rd_err != 0) begin errors++; $display("FAIL gap_rd_when_empty got %0d want 0", empty_rd_err); end
    checks++; if (to || got_q.size() != cnt) begin errors++; $display("FAIL gap_count got %0d want %0d", got_q.size(), cnt); end
    for (int i = 0; i < got_q.size() && i < cnt; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] words[$];
    bit to;
    do_reset();
    stereo = 1'b1; sample_size = 5'd0; m_ready = 1'b1;
    push_word(32'hAAAA_0001);
    en = 1'b1;
    for (int i = 0; i < 20 && rd_cnt < 1; i++) tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    checks++; if (rd_cnt != 1) begin errors++; $display("FAIL abort_orphan_pop got %0d want 1", rd_cnt); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state got %0d want 0", dbg_state); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL abort_frame_cnt got %0d want 0", frame_cnt); end
    for (int i = 0; i < 2 * DECIM_F; i++) begin
      words.push_back($urandom());
      push_word(words[i]);
    end
    model_frames(words, 1'b1, 0);
    en = 1'b1;
    wait_frames(1, 60, 1'b0, to);
    repeat (3) tick();
    checks++; if (to || got_q.size() != 1) begin errors++; $display("FAIL abort_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_data got %h want %h", got_q[0], exp_q[0]); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL abort_frame_cnt_after got %0d want 1", frame_cnt); end
  endtask

  task automatic test_en_drop_in_send();
    bit seen;
    do_reset();
    stereo = 1'b0; sample_size = 5'd0; m_ready = 1'b0;
    for (int i = 0; i < DECIM_F; i++) push_word($urandom());
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = (m_valid === 1'b1);
    end
    checks++; if (!seen) begin errors++; $display("FAIL endrop_reach_send got 0 want 1"); end
    m_ready = 1'b1;
    en = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL endrop_valid got %b want 0", m_valid); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL endrop_frame_cnt got %0d want 1", frame_cnt); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL endrop_accepted got %0d want 1", got_q.size()); end
  endtask

  task automatic test_random();
    logic [DW-1:0] words[$];
    bit to, st;
    int n, cnt, nw;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      words.delete();
      st = 1'($urandom_range(0, 1)); n = $urandom_range(0, 31);
      stereo = st; sample_size = 5'(n);
      nw = 4 * DECIM_F * $urandom_range(2, 6);
      for (int i = 0; i < nw; i++) begin
        words.push_back($urandom());
        push_word(words[i]);
      end
      model_frames(words, st, n);
      cnt = exp_q.size();
      en = 1'b1;
      wait_frames(cnt, 600, 1'b1, to);
      repeat (3) tick();
      checks++; if (to || got_q.size() != cnt) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, got_q.size(), cnt); end
      for (int i = 0; i < got_q.size() && i < cnt; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
      checks++; if (frame_cnt !== 16'(cnt)) begin errors++; $display("FAIL rand%0d_frame_cnt got %0d want %0d", r, frame_cnt, cnt); end
      checks++; if (consec_err != 0 || empty_rd_err != 0 || send_rd_err != 0 || hold_err != 0) begin
        errors++; $display("FAIL rand%0d_protocol got %0d/%0d/%0d/%0d want 0/0/0/0", r, consec_err, empty_rd_err, send_rd_err, hold_err); end
    end
  endtask

  // Test sequence and final report.
  initial begin
    rst = 1'b1; en = 1'b0; stereo = 1'b0; sample_size = 5'd0; m_ready = 1'b0;
    refresh_fifo();
    test_reset();
`ifndef I2S_DRAIN_DECIM2_EN
    test_stereo18();
    test_mono16();
`else
    test_decim8();
`endif
    test_backpressure();
    test_gap();
    test_abort();
    test_en_drop_in_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
